cfu_l1_rr_mux: RTL and testbench
================================

Name: cfu_l1_rr_mux

Overview:
- Shares one fixed-latency (CFU-L1) CFU, e.g. the dot-product CFU, among N_REQ requesters (harts or accelerators).
- Each requester has a valid/ready request channel and a valid-only response channel.
- Round-robin arbitration issues at most one request per cycle downstream.
- A requester-index tag travels through a CFU_LATENCY-deep shift register, so each response is steered back to the requester that issued it.

Parameters:
- N_REQ, 2: number of requesters (>=2).
- CFU_LATENCY, 0: downstream CFU fixed latency in cycles. Must equal the downstream CFU's value.
- CFU_CFU_ID_W, 0: request CFU ID width, passed through.
- CFU_STATE_ID_W, 1: requester-side state ID width.
- CFU_FUNC_ID_W, $bits(cfid_t): function ID width.
- CFU_DATA_W, 32: operand/result width.
- IDX_W, $clog2(N_REQ): requester index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  clock enable, shared with the downstream CFU.
- up_req_valid  in  N_REQ  per-requester request valid.
- up_req_ready  out  N_REQ  per-requester request accepted this cycle.
- up_req_cfu  in  N_REQ x CFU_CFU_ID_W  CFU ID.
- up_req_state  in  N_REQ x CFU_STATE_ID_W  state ID.
- up_req_func  in  N_REQ x CFU_FUNC_ID_W  function ID.
- up_req_data0, up_req_data1  in  N_REQ x CFU_DATA_W  operands.
- up_resp_valid  out  N_REQ  per-requester response valid.
- up_resp_status  out  N_REQ x cfu_status_t  response status.
- up_resp_data  out  N_REQ x CFU_DATA_W  response data.
- req_valid, req_cfu, req_state, req_func, req_data0, req_data1  out  to the downstream CFU.
  - req_state width is CFU_STATE_ID_W, or CFU_STATE_ID_W+IDX_W with the optional feature.
- resp_valid, resp_status, resp_data  in  from the downstream CFU.
- orphan_err  out  1  sticky: a response arrived with no matching tag.

Behaviour:
- Arbitration is combinational over up_req_valid, starting from the priority pointer ptr (an IDX_W flop).
  - The grant goes to the first valid index at or after ptr, wrapping modulo N_REQ.
- up_req_ready[g] = clk_en && up_req_valid[g] for the winner g; all other ready bits are 0.
- No request is issued while clk_en=0.
- req_valid = |up_req_ready. Downstream req_* fields are muxed from the winner. The fields are don't-care when req_valid=0, but are driven from index 0 so nothing is X.
- On a handshake, ptr <= (g+1) mod N_REQ. This bounds starvation: a continuously valid requester waits at most N_REQ-1 grants.
- With no request, ptr holds.
- Tag pipe: shift_reg of width 1+IDX_W and depth CFU_LATENCY, clocked with clk_en. Input is {req_valid, g}; output is {tag_v, tag_idx}.
  - CFU_LATENCY=0 means a pure wire: the response is routed in the same cycle.
- Response routing:
  - up_resp_valid[i] = resp_valid && tag_v && tag_idx==i.
  - up_resp_status and up_resp_data are broadcast to all requesters; consumers qualify them with their own valid bit.
- orphan_err is set when resp_valid && !tag_v, or when tag_v && !resp_valid (latency mismatch). It clears only on rst.
- Reset state:
  - ptr=0, tag pipe cleared, orphan_err=0.
  - All up_req_ready, up_resp_valid and req_valid are 0 during rst and in the first cycle after it unless a request is present.
  - Outputs are combinational from inputs apart from the flops listed above.
- Reset mid-operation drops in-flight tags. The downstream CFU shares rst, so its responses are dropped too; there is no orphan.
- Simultaneous response delivery and new issue in the same cycle is legal; throughput is one request per cycle.
- clk_en=0 freezes ptr and the tag pipe. Responses still present at the downstream output stay routed to the same index.

Optional Feature:
- Macro: CFU_L1_RR_MUX_STATE_PART_EN.
- Defined: each requester gets a private set of downstream state contexts.
  - req_state = {g, up_req_state[g]}, width CFU_STATE_ID_W+IDX_W.
  - The downstream CFU_STATE_ID_MAX must be sized to N_REQ * 2**CFU_STATE_ID_W.
- Undefined: req_state = up_req_state[g] unchanged, so requesters share contexts.

Decomposition:
- cfu_pkg supplies cfu_status_t and cfid_t.
- A new rr_pkg holds a function rr_pick(valid, ptr) returning {found, idx}, plus the req_idx_t typedef.
- Natural sub-module: rr_arbiter.
  - Contents: ptr flop, grant logic, pointer advance on an accept input.
  - Reusable by other shared-resource blocks.
- The tag pipe reuses the existing shift_reg.

Test Plan:
1. N_REQ=2, CFU_LATENCY=0, downstream dotprod CFU with ELEM_W=8. Req0 issues dotprod with data0=0x01020304, data1=0x01010101 -> up_resp_valid[0]=1 in the same cycle with data 10, status CFU_OK; up_resp_valid[1]=0.
2. Both requesters valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; each requester receives exactly 3 responses.
3. CFU_LATENCY=3, req1 issues at cycle t and req0 at t+1 -> up_resp_valid[1] at t+3 and up_resp_valid[0] at t+4; data matches each requester's operands.
4. clk_en low for 2 cycles with requests pending and one in flight -> no ready asserted, ptr unchanged, response delayed by exactly 2 cycles and routed to the correct requester.
5. rst asserted with 2 responses in flight (CFU_LATENCY=3) -> no up_resp_valid afterwards, orphan_err=0, first post-reset grant goes to index 0.
6. With CFU_L1_RR_MUX_STATE_PART_EN: req1 write_state 0x55 at state 0, then req0 read_state at state 0 -> req0 reads 0; req1 reads back 0x55.

Source files
------------

// File: rtl/cfu_pkg.sv
// Shared CFU-L1 interface types: response status and function ID.
package cfu_pkg;

    typedef enum logic [2:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_CFU    = 3'd1,
        CFU_ERROR_OFF    = 3'd2,
        CFU_ERROR_STATE  = 3'd3,
        CFU_ERROR_FUNC   = 3'd4,
        CFU_ERROR_OP     = 3'd5,
        CFU_ERROR_CUSTOM = 3'd6
    } cfu_status_t;

    typedef logic [9:0] cfid_t;

endpackage

// File: rtl/rr_pkg.sv
// Round-robin helpers shared by arbiters: requester index type and the
// rotating first-valid pick.
package rr_pkg;

    localparam int unsigned RR_MAX_N     = 32;
    localparam int unsigned RR_IDX_MAX_W = 5;

    typedef logic [RR_IDX_MAX_W-1:0] req_idx_t;

    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping modulo n; idx is 0 when none.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                         input req_idx_t ptr,
                                         input int unsigned n);
        rr_pick_t    res;
        int unsigned cand;
        res  = '0;
        cand = 0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            cand = (32'(ptr) + k) % n;
            if (k < n && !res.found && valid[cand[RR_IDX_MAX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = req_idx_t'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from a rotating priority pointer,
// pointer moves past the winner whenever the grant is accepted.
module rr_arbiter
    import rr_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid,
    input  logic             accept,
    output logic             found_c,
    output logic [IDX_W-1:0] grant_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    rr_pick_t         pick;

    always_comb begin
        pick        = rr_pick(RR_MAX_N'(valid), req_idx_t'(ptr_q), N_REQ);
        found_c     = pick.found;
        grant_idx_c = IDX_W'(pick.idx);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_idx_c == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_reg.sv
// Fixed-depth enable-gated delay line; DEPTH=0 degenerates to a wire.
module shift_reg #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, en};
        assign q         = d;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DEPTH];
        logic [W-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rst) begin
                    stage_q[i] <= '0;
                end else if (en) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/cfu_l1_rr_mux.sv
// Shares one fixed-latency CFU among N_REQ requesters with round-robin issue
// and tag-steered responses. Optional CFU_L1_RR_MUX_STATE_PART_EN prefixes
// req_state with the requester index to give each requester private contexts.
module cfu_l1_rr_mux
    import cfu_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned CFU_LATENCY    = 0,
    parameter int unsigned CFU_CFU_ID_W   = 0,
    parameter int unsigned CFU_STATE_ID_W = 1,
    parameter int unsigned CFU_FUNC_ID_W  = $bits(cfid_t),
    parameter int unsigned CFU_DATA_W     = 32,
    parameter int unsigned IDX_W          = $clog2(N_REQ),
    // A zero-width CFU ID is carried as one tied-off bit.
    localparam int unsigned CFU_ID_PW     = (CFU_CFU_ID_W == 0) ? 1 : CFU_CFU_ID_W,
`ifdef CFU_L1_RR_MUX_STATE_PART_EN
    localparam int unsigned REQ_STATE_W   = CFU_STATE_ID_W + IDX_W
`else
    localparam int unsigned REQ_STATE_W   = CFU_STATE_ID_W
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clk_en,
    input  logic [N_REQ-1:0]                      up_req_valid,
    output logic [N_REQ-1:0]                      up_req_ready,
    input  logic [N_REQ-1:0][CFU_ID_PW-1:0]       up_req_cfu,
    input  logic [N_REQ-1:0][CFU_STATE_ID_W-1:0]  up_req_state,
    input  logic [N_REQ-1:0][CFU_FUNC_ID_W-1:0]   up_req_func,
    input  logic [N_REQ-1:0][CFU_DATA_W-1:0]      up_req_data0,
    input  logic [N_REQ-1:0][CFU_DATA_W-1:0]      up_req_data1,
    output logic [N_REQ-1:0]                      up_resp_valid,
    output cfu_status_t [N_REQ-1:0]               up_resp_status,
    output logic [N_REQ-1:0][CFU_DATA_W-1:0]      up_resp_data,
    output logic                                  req_valid,
    output logic [CFU_ID_PW-1:0]                  req_cfu,
    output logic [REQ_STATE_W-1:0]                req_state,
    output logic [CFU_FUNC_ID_W-1:0]              req_func,
    output logic [CFU_DATA_W-1:0]                 req_data0,
    output logic [CFU_DATA_W-1:0]                 req_data1,
    input  logic                                  resp_valid,
    input  cfu_status_t                           resp_status,
    input  logic [CFU_DATA_W-1:0]                 resp_data,
    output logic                                  orphan_err
);

    logic             found;
    logic [IDX_W-1:0] grant;
    logic [IDX_W:0]   tag_in;
    logic [IDX_W:0]   tag_out;
    logic             tag_v;
    logic [IDX_W-1:0] tag_idx;
    logic             orphan_err_q;
    logic             orphan_err_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid       (up_req_valid),
        .accept      (req_valid),
        .found_c     (found),
        .grant_idx_c (grant)
    );

    // Issue side: grant is 0 when idle, so the muxed fields stay defined.
    always_comb begin
        up_req_ready = '0;
        if (clk_en && !rst && found) begin
            up_req_ready[grant] = 1'b1;
        end
        req_valid = |up_req_ready;
        req_cfu   = up_req_cfu[grant];
        req_func  = up_req_func[grant];
        req_data0 = up_req_data0[grant];
        req_data1 = up_req_data1[grant];
`ifdef CFU_L1_RR_MUX_STATE_PART_EN
        req_state = {grant, up_req_state[grant]};
`else
        req_state = up_req_state[grant];
`endif
    end

    assign tag_in = {req_valid, grant};

    shift_reg #(
        .W     (IDX_W + 1),
        .DEPTH (CFU_LATENCY)
    ) u_tag_pipe (
        .clk (clk),
        .rst (rst),
        .en  (clk_en),
        .d   (tag_in),
        .q   (tag_out)
    );

    assign {tag_v, tag_idx} = tag_out;

    // Response side: status/data broadcast, valid steered by the returning tag.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            up_resp_valid[i]  = !rst && resp_valid && tag_v && (tag_idx == IDX_W'(i));
            up_resp_status[i] = resp_status;
            up_resp_data[i]   = resp_data;
        end
        orphan_err_d = orphan_err_q | (resp_valid ^ tag_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_err_q <= 1'b0;
        end else begin
            orphan_err_q <= orphan_err_d;
        end
    end

    assign orphan_err = orphan_err_q;

endmodule

// File: tb/tb_cfu_l1_rr_mux.sv
// Directed bench for cfu_l1_rr_mux: instance 0 at latency 0, instance 1 at
// latency 3, each driving a small dot-product/state CFU model.
module tb_cfu_l1_rr_mux;
    import cfu_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 1;
    localparam int unsigned CW = 1;
    localparam int unsigned FW = $bits(cfid_t);
`ifdef CFU_L1_RR_MUX_STATE_PART_EN
    localparam int unsigned RSW = SW + 1;
`else
    localparam int unsigned RSW = SW;
`endif
    localparam cfid_t F_DOT = 10'd0;
    localparam cfid_t F_WR  = 10'd1;
    localparam cfid_t F_RD  = 10'd2;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  v;
        logic [1:0]  rdy;
        logic [1:0]  rv;
        logic [31:0] data;
    } vec_t;

    logic clk;
    logic rst;
    logic clk_en [2];

    logic [N-1:0]          up_valid [2];
    logic [N-1:0]          up_ready [2];
    logic [N-1:0][CW-1:0]  up_cfu   [2];
    logic [N-1:0][SW-1:0]  up_state [2];
    logic [N-1:0][FW-1:0]  up_func  [2];
    logic [N-1:0][DW-1:0]  up_d0    [2];
    logic [N-1:0][DW-1:0]  up_d1    [2];
    logic [N-1:0]          up_rv    [2];
    cfu_status_t [N-1:0]   up_rs    [2];
    logic [N-1:0][DW-1:0]  up_rd    [2];
    logic                  req_valid   [2];
    logic [CW-1:0]         req_cfu     [2];
    logic [RSW-1:0]        req_state   [2];
    logic [FW-1:0]         req_func    [2];
    logic [DW-1:0]         req_d0      [2];
    logic [DW-1:0]         req_d1      [2];
    logic                  resp_valid  [2];
    cfu_status_t           resp_status [2];
    logic [DW-1:0]         resp_data   [2];
    logic                  orphan      [2];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 0 : 3;

        cfu_l1_rr_mux #(
            .N_REQ          (N),
            .CFU_LATENCY    (LAT),
            .CFU_CFU_ID_W   (0),
            .CFU_STATE_ID_W (SW),
            .CFU_FUNC_ID_W  (FW),
            .CFU_DATA_W     (DW)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .clk_en         (clk_en[k]),
            .up_req_valid   (up_valid[k]),
            .up_req_ready   (up_ready[k]),
            .up_req_cfu     (up_cfu[k]),
            .up_req_state   (up_state[k]),
            .up_req_func    (up_func[k]),
            .up_req_data0   (up_d0[k]),
            .up_req_data1   (up_d1[k]),
            .up_resp_valid  (up_rv[k]),
            .up_resp_status (up_rs[k]),
            .up_resp_data   (up_rd[k]),
            .req_valid      (req_valid[k]),
            .req_cfu        (req_cfu[k]),
            .req_state      (req_state[k]),
            .req_func       (req_func[k]),
            .req_data0      (req_d0[k]),
            .req_data1      (req_d1[k]),
            .resp_valid     (resp_valid[k]),
            .resp_status    (resp_status[k]),
            .resp_data      (resp_data[k]),
            .orphan_err     (orphan[k])
        );

        // Downstream CFU model: 8-bit dot product plus a small state store.
        logic [DW-1:0] mem [4];
        logic [DW-1:0] res_c;
        cfu_status_t   st_c;

        always_comb begin
            res_c = '0;
            st_c  = CFU_OK;
            case (cfid_t'(req_func[k]))
                F_DOT: for (int b = 0; b < 4; b++)
                           res_c += DW'(req_d0[k][8*b +: 8]) * DW'(req_d1[k][8*b +: 8]);
                F_WR:  res_c = '0;
                F_RD:  res_c = mem[2'(req_state[k])];
                default: st_c = CFU_ERROR_OP;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mem <= '{default: '0};
            end else if (clk_en[k] && req_valid[k] && cfid_t'(req_func[k]) == F_WR) begin
                mem[2'(req_state[k])] <= req_d0[k];
            end
        end

        if (LAT == 0) begin : g_comb
            assign resp_valid[k]  = req_valid[k];
            assign resp_status[k] = st_c;
            assign resp_data[k]   = res_c;
        end else begin : g_pipe
            logic          pv [LAT];
            logic [DW-1:0] pd [LAT];
            cfu_status_t   ps [LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
                end else if (clk_en[k]) begin
                    pv[0] <= req_valid[k];
                    pd[0] <= res_c;
                    ps[0] <= st_c;
                    for (int i = 1; i < LAT; i++) begin
                        pv[i] <= pv[i-1];
                        pd[i] <= pd[i-1];
                        ps[i] <= ps[i-1];
                    end
                end
            end
            assign resp_valid[k]  = pv[LAT-1];
            assign resp_status[k] = ps[LAT-1];
            assign resp_data[k]   = pd[LAT-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of a vector on instance k and check it before the next edge.
    task automatic apply(input int k, input vec_t r, input string tag);
        @(negedge clk);
        rst         = r.rst;
        clk_en[k]   = r.en;
        up_valid[k] = r.v;
        #1;
        chk({tag, " ready"},      32'(up_ready[k]),  32'(r.rdy));
        chk({tag, " req_valid"},  32'(req_valid[k]), 32'(|r.rdy));
        chk({tag, " resp_valid"}, 32'(up_rv[k]),     32'(r.rv));
        for (int i = 0; i < 2; i++) begin
            if (r.rv[i]) begin
                chk($sformatf("%s data[%0d]", tag, i),   up_rd[k][i],      r.data);
                chk($sformatf("%s status[%0d]", tag, i), 32'(up_rs[k][i]), 32'(CFU_OK));
            end
        end
        chk({tag, " orphan"}, 32'(orphan[k]), 32'd0);
    endtask

    vec_t tab0 [15];
    vec_t tab3 [20];
    int   cnt  [2];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clk_en[k]      = 1'b1;
            up_valid[k]    = '0;
            up_cfu[k]      = '0;
            up_state[k]    = '0;
            up_func[k][0]  = F_DOT;
            up_func[k][1]  = F_DOT;
            up_d0[k][0]    = 32'h0102_0304;
            up_d1[k][0]    = 32'h0101_0101;
            up_d0[k][1]    = 32'h0202_0202;
            up_d1[k][1]    = 32'h0303_0303;
        end
        cnt[0] = 0;
        cnt[1] = 0;

        // Latency 0: req0 result 10, req1 result 4*6 = 24.
        tab0[0]  = '{1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 32'd0};
        tab0[1]  = '{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab0[2]  = '{1'b0, 1'b1, 2'b11, 2'b01, 2'b01, 32'd10};
        tab0[3]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b10, 32'd24};
        tab0[4]  = '{1'b0, 1'b1, 2'b11, 2'b01, 2'b01, 32'd10};
        tab0[5]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b10, 32'd24};
        tab0[6]  = '{1'b0, 1'b1, 2'b11, 2'b01, 2'b01, 32'd10};
        tab0[7]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b10, 32'd24};
        tab0[8]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 32'd10};
        tab0[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab0[10] = '{1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 32'd0};
        tab0[11] = '{1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 32'd0};
        tab0[12] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b10, 32'd24};
        tab0[13] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b10, 32'd24};
        tab0[14] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 32'd10};

        // Latency 3: ordering, clk_en stall, reset with two responses in flight.
        tab3[0]  = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 32'd0};
        tab3[1]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 32'd0};
        tab3[2]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[3]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 32'd24};
        tab3[4]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 32'd10};
        tab3[5]  = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 32'd0};
        tab3[6]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 32'd0};
        tab3[7]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 32'd0};
        tab3[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[10] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 32'd24};
        tab3[11] = '{1'b0, 1'b1, 2'b11, 2'b01, 2'b00, 32'd0};
        tab3[12] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 32'd0};
        tab3[13] = '{1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 32'd0};
        tab3[14] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[15] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[16] = '{1'b0, 1'b1, 2'b11, 2'b01, 2'b00, 32'd0};
        tab3[17] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[18] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0};
        tab3[19] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 32'd10};

        for (int r = 0; r < 15; r++) begin
            apply(0, tab0[r], $sformatf("l0 row%0d", r));
            if (r >= 2 && r <= 7) begin
                cnt[0] += int'(up_rv[0][0]);
                cnt[1] += int'(up_rv[0][1]);
            end
        end
        chk("l0 resp count req0", 32'(cnt[0]), 32'd3);
        chk("l0 resp count req1", 32'(cnt[1]), 32'd3);

        // State contexts: req1 writes 0x55 to state 0, then both read state 0.
        @(negedge clk);
        up_func[0][1]  = F_WR;
        up_d0[0][1]    = 32'h55;
        up_valid[0]    = 2'b10;
        #1;
        chk("st wr ready", 32'(up_ready[0]), 32'(2'b10));
`ifdef CFU_L1_RR_MUX_STATE_PART_EN
        chk("st wr req_state", 32'(req_state[0]), 32'd2);
`else
        chk("st wr req_state", 32'(req_state[0]), 32'd0);
`endif
        @(negedge clk);
        up_func[0][0]  = F_RD;
        up_func[0][1]  = F_RD;
        up_valid[0]    = 2'b01;
        #1;
        chk("st rd0 resp_valid", 32'(up_rv[0]), 32'(2'b01));
`ifdef CFU_L1_RR_MUX_STATE_PART_EN
        chk("st rd0 data", up_rd[0][0], 32'h0);
`else
        chk("st rd0 data", up_rd[0][0], 32'h55);
`endif
        @(negedge clk);
        up_valid[0]    = 2'b10;
        #1;
        chk("st rd1 resp_valid", 32'(up_rv[0]), 32'(2'b10));
        chk("st rd1 data", up_rd[0][1], 32'h55);
        @(negedge clk);
        up_valid[0]    = 2'b00;
        up_func[0][0]  = F_DOT;
        up_func[0][1]  = F_DOT;

        for (int r = 0; r < 20; r++) begin
            apply(1, tab3[r], $sformatf("l3 row%0d", r));
        end
        chk("l0 orphan final", 32'(orphan[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
